// File: rtl/wb_sched_pkg.sv
// ============================================================================
// Module      : wb_sched_pkg
// Description : Shared core types for the writeback scheduler: register index,
//               data word, register count and the writeback request record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_sched_pkg;

    // Architectural register file size (r0 is hard-wired zero).
    localparam int NUM_REGS = 32;

    // Register index and data word of the integer core.
    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    // One writeback request as seen by the register-file write port.
    typedef struct packed {
        reg_idx_t rd;
        word_t    val;
    } wb_req_t;

endpackage : wb_sched_pkg

`default_nettype wire

// File: rtl/wb_rr_arb.sv
// ============================================================================
// Module      : wb_rr_arb
// Description : Two-way round-robin arbiter between the execute-stage and the
//               load-return writeback requesters. Grants depend only on the
//               valid inputs and the pointer; the pointer flips on contention.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_rr_arb #(
    parameter logic RR_INIT = 1'b1      // 1: load requester wins the first tie
) (
    input  logic clk,
    input  logic rst_n,
    input  logic alu_valid_i,
    input  logic ld_valid_i,
    output logic alu_grant_o,
    output logic ld_grant_o
);

    // Pointer: 1 = load wins the next tie, 0 = execute wins the next tie.
    logic ptr_q;
    logic ptr_d;
    logic w_both;

    // Grant selection and pointer next-state; pointer only moves on a tie so
    // that a lone requester never steals the other's turn.
    always_comb begin
        w_both      = alu_valid_i & ld_valid_i;
        ld_grant_o  = ld_valid_i  & (~alu_valid_i | ptr_q);
        alu_grant_o = alu_valid_i & (~ld_valid_i  | ~ptr_q);
        ptr_d       = w_both ? ~ptr_q : ptr_q;
    end

    // Pointer flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= RR_INIT;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : wb_rr_arb

`default_nettype wire

// File: rtl/wb_sched.sv
// ============================================================================
// Module      : wb_sched
// Description : Register scoreboard and writeback scheduler. Tracks busy
//               destination registers, stalls issue on RAW/WAW hazards, and
//               arbitrates two writeback sources onto one registered
//               register-file write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_sched
    import wb_sched_pkg::*;
#(
    parameter logic RR_INIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    // Decode / issue
    input  logic        issue_valid_i,
    input  logic [4:0]  issue_rd_i,
    input  logic [4:0]  issue_rs1_i,
    input  logic [4:0]  issue_rs2_i,
    input  logic [4:0]  issue_rs3_i,
    output logic        issue_stall_o,
    // Execute-stage writeback request
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_val_i,
    output logic        alu_ready_o,
    // Load-return writeback request
    input  logic        ld_valid_i,
    input  logic [4:0]  ld_rd_i,
    input  logic [31:0] ld_val_i,
    output logic        ld_ready_o,
    // Register-file write port
    output logic        w_rd_o,
    output logic [4:0]  rd_o,
    output logic [31:0] rd_val_o,
    output logic        idle_o
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:1] busy_q;
    logic [NUM_REGS-1:1] busy_d;
    logic                w_rd_q;
    logic                w_rd_d;
    reg_idx_t            rd_q;
    reg_idx_t            rd_d;
    word_t               rd_val_q;
    word_t               rd_val_d;

    // r0 never reads as busy: a constant zero sits below the busy flops.
    logic [NUM_REGS-1:0] w_busy_vec;
    logic                w_issue_fire;
    logic                w_accept;
    wb_req_t             w_acc_req;

    assign w_busy_vec = {busy_q, 1'b0};

    // Hazard check straight off the scoreboard; no bypass from the write
    // port, so a register stays blocked through its own write cycle.
    always_comb begin
        issue_stall_o = issue_valid_i &
                        (w_busy_vec[issue_rs1_i] | w_busy_vec[issue_rs2_i] |
                         w_busy_vec[issue_rs3_i] | w_busy_vec[issue_rd_i]);
        w_issue_fire  = issue_valid_i & ~issue_stall_o;
    end

    // ------------------------------------------------------------------
    // Writeback arbitration
    // ------------------------------------------------------------------
    wb_rr_arb #(
        .RR_INIT     (RR_INIT)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid_i (alu_valid_i),
        .ld_valid_i  (ld_valid_i),
        .alu_grant_o (alu_ready_o),
        .ld_grant_o  (ld_ready_o)
    );

    // Capture the accepted request; an rd=0 request is consumed without a
    // write, and the port holds its last value whenever nothing is written.
    always_comb begin
        w_accept  = alu_ready_o | ld_ready_o;
        w_acc_req = ld_ready_o ? '{rd: ld_rd_i,  val: ld_val_i}
                               : '{rd: alu_rd_i, val: alu_val_i};
        w_rd_d    = w_accept && (w_acc_req.rd != '0);
        rd_d      = w_rd_d ? w_acc_req.rd  : rd_q;
        rd_val_d  = w_rd_d ? w_acc_req.val : rd_val_q;
    end

    // ------------------------------------------------------------------
    // Scoreboard next-state: a bit clears at the end of its write cycle and
    // sets on a firing issue; different registers may do both at one edge.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
            assign busy_d[gi] =
                (busy_q[gi] & ~(w_rd_q && (rd_q == reg_idx_t'(gi)))) |
                (w_issue_fire && (issue_rd_i == reg_idx_t'(gi)));
        end
    endgenerate

    // Scoreboard and write-port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            w_rd_q   <= 1'b0;
            rd_q     <= '0;
            rd_val_q <= '0;
        end else begin
            busy_q   <= busy_d;
            w_rd_q   <= w_rd_d;
            rd_q     <= rd_d;
            rd_val_q <= rd_val_d;
        end
    end

    assign w_rd_o   = w_rd_q;
    assign rd_o     = rd_q;
    assign rd_val_o = rd_val_q;
    assign idle_o   = ~(|busy_q) & ~w_rd_q;

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
    // Issue stalls on a busy rd, so a clear and a set of one register can
    // never land on the same edge.
    a_no_clr_set_same : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(w_rd_q && w_issue_fire && (issue_rd_i == rd_q) && (rd_q != '0))
    );

    // A writeback to a register nobody is waiting on is still performed but
    // indicates a broken producer.
    a_wb_to_busy : assert property (
        @(posedge clk) disable iff (!rst_n)
        (w_accept && (w_acc_req.rd != '0)) |-> w_busy_vec[w_acc_req.rd]
    );

endmodule : wb_sched

`default_nettype wire

// File: tb/tb_wb_sched.sv
// ============================================================================
// Module      : tb_wb_sched
// Description : Self-checking bench for wb_sched. A transaction-level model
//               (busy set, tie-turn flag, request queues) predicts stall,
//               ready and idle each cycle and pushes expected writes into a
//               scoreboard that a separate monitor drains from the write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_sched;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
    } req_t;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0, issue_rs1 = '0, issue_rs2 = '0, issue_rs3 = '0;
    logic        issue_stall;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_val = '0;
    logic        alu_ready;
    logic        ld_valid = 1'b0;
    logic [4:0]  ld_rd = '0;
    logic [31:0] ld_val = '0;
    logic        ld_ready;
    logic        w_rd;
    logic [4:0]  rd;
    logic [31:0] rd_val;
    logic        idle;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state
    bit          m_busy [32];
    bit          m_tie_ld;
    bit          m_wr_now;
    logic [4:0]  m_wr_rd;
    bit          m_fired;
    bit          rand_mode;
    int          n_acc_ld, n_acc_alu;
    req_t        alu_q [$];
    req_t        ld_q  [$];
    exp_t        exp_q [$];
    logic [4:0]  owed  [$];
    logic [4:0]  last_rd;
    logic [31:0] last_val;

    wb_sched #(.RR_INIT(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .issue_rs1_i   (issue_rs1),
        .issue_rs2_i   (issue_rs2),
        .issue_rs3_i   (issue_rs3),
        .issue_stall_o (issue_stall),
        .alu_valid_i   (alu_valid),
        .alu_rd_i      (alu_rd),
        .alu_val_i     (alu_val),
        .alu_ready_o   (alu_ready),
        .ld_valid_i    (ld_valid),
        .ld_rd_i       (ld_rd),
        .ld_val_i      (ld_val),
        .ld_ready_o    (ld_ready),
        .w_rd_o        (w_rd),
        .rd_o          (rd),
        .rd_val_o      (rd_val),
        .idle_o        (idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit mb(input logic [4:0] r);
        return (r != 5'd0) && m_busy[r];
    endfunction

    function automatic bit any_busy();
        bit a = 1'b0;
        for (int i = 1; i < 32; i++) a |= m_busy[i];
        return a;
    endfunction

    // Present the head of each requester queue; held until accepted.
    task automatic drive_reqs();
        alu_valid = (alu_q.size() > 0);
        alu_rd    = alu_valid ? alu_q[0].rd  : 5'd0;
        alu_val   = alu_valid ? alu_q[0].val : 32'd0;
        ld_valid  = (ld_q.size() > 0);
        ld_rd     = ld_valid ? ld_q[0].rd  : 5'd0;
        ld_val    = ld_valid ? ld_q[0].val : 32'd0;
    endtask

    // Predict this cycle's combinational outputs, then advance the model
    // across the coming clock edge.
    task automatic model_cycle();
        bit   st, ga, gl, acc;
        req_t r;
        st = issue_valid && (mb(issue_rs1) || mb(issue_rs2) || mb(issue_rs3) || mb(issue_rd));
        if (alu_q.size() > 0 && ld_q.size() > 0) begin
            gl = m_tie_ld;
            ga = !m_tie_ld;
            m_tie_ld = !m_tie_ld;
        end else begin
            gl = (ld_q.size() > 0);
            ga = (alu_q.size() > 0);
        end
        chk("stall",     issue_stall, st);
        chk("alu_ready", alu_ready,   ga);
        chk("ld_ready",  ld_ready,    gl);
        chk("idle",      idle,        !any_busy() && !m_wr_now);

        if (m_wr_now) m_busy[m_wr_rd] = 1'b0;
        m_fired = issue_valid && !st;
        if (m_fired && issue_rd != 5'd0) begin
            m_busy[issue_rd] = 1'b1;
            if (rand_mode) owed.push_back(issue_rd);
        end
        acc = 1'b0;
        r   = '{5'd0, 32'd0};
        if (gl) begin
            r = ld_q.pop_front();  acc = 1'b1; n_acc_ld++;
        end else if (ga) begin
            r = alu_q.pop_front(); acc = 1'b1; n_acc_alu++;
        end
        m_wr_now = acc && (r.rd != 5'd0);
        if (m_wr_now) begin
            m_wr_rd = r.rd;
            exp_q.push_back('{cyc + 1, r.rd, r.val});
        end
    endtask

    task automatic step();
        drive_reqs();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    // Hold an instruction at issue until it fires; n = cycles presented.
    task automatic issue_wait(input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [4:0] s3, output int n);
        issue_valid = 1'b1;
        issue_rd = d; issue_rs1 = s1; issue_rs2 = s2; issue_rs3 = s3;
        n = 0;
        do begin
            step();
            n++;
        end while (!m_fired && n < 20);
        issue_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_tie_ld = 1'b1;
        m_wr_now = 1'b0;
        m_wr_rd  = 5'd0;
        alu_q.delete(); ld_q.delete(); exp_q.delete(); owed.delete();
        last_rd  = 5'd0;
        last_val = 32'd0;
        issue_valid = 1'b0;
        drive_reqs();
        @(negedge clk);
        chk("rst_w_rd",   w_rd,   1'b0);
        chk("rst_rd",     rd,     5'd0);
        chk("rst_rd_val", rd_val, 32'd0);
        chk("rst_idle",   idle,   1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic refill(input bit is_ld);
        req_t r;
        int   idx;
        if ((is_ld ? ld_q.size() : alu_q.size()) != 0) return;
        if (owed.size() > 0 && $urandom_range(0, 1) == 1) begin
            idx = $urandom_range(0, owed.size() - 1);
            r   = '{owed[idx], $urandom};
            owed.delete(idx);
        end else if ($urandom_range(0, 15) == 0) begin
            r = '{5'd0, $urandom};
        end else begin
            return;
        end
        if (is_ld) ld_q.push_back(r);
        else       alu_q.push_back(r);
    endtask

    // Write-port monitor: the scoreboard head is due exactly in its cycle;
    // otherwise the port must be quiet and hold its last value.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_valid", w_rd,   1'b1);
                chk("wr_rd",    rd,     e.rd);
                chk("wr_val",   rd_val, e.val);
                last_rd  = e.rd;
                last_val = e.val;
            end else begin
                chk("wr_quiet",    w_rd,   1'b0);
                chk("hold_rd",     rd,     last_rd);
                chk("hold_rd_val", rd_val, last_val);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, a0, l0;
        rand_mode = 1'b0;
        #1;
        do_reset();

        // RAW: r5 written by the execute stage releases a dependent read.
        issue_wait(5'd5, 5'd0, 5'd0, 5'd0, n);
        chk("raw_first_issue", n, 1);
        alu_q.push_back('{5'd5, 32'h0000_0055});
        issue_wait(5'd0, 5'd5, 5'd0, 5'd0, n);
        chk("raw_release_cycles", n, 3);

        // Tie from reset: load first, then execute.
        issue_wait(5'd3, 5'd0, 5'd0, 5'd0, n);
        issue_wait(5'd7, 5'd0, 5'd0, 5'd0, n);
        alu_q.push_back('{5'd3, 32'h11});
        ld_q.push_back('{5'd7, 32'h22});
        l0 = n_acc_ld;
        step();
        chk("tie_first_is_ld", n_acc_ld - l0, 1);
        step(); step();

        // Sustained contention: strict alternation, 3 each, no idle cycle.
        for (int i = 10; i < 16; i++) issue_wait(5'(i), 5'd0, 5'd0, 5'd0, n);
        for (int i = 0; i < 3; i++) begin
            alu_q.push_back('{5'(10 + i), $urandom});
            ld_q.push_back('{5'(13 + i), $urandom});
        end
        a0 = n_acc_alu; l0 = n_acc_ld;
        for (int i = 0; i < 6; i++) step();
        chk("alt_alu_count", n_acc_alu - a0, 3);
        chk("alt_ld_count",  n_acc_ld  - l0, 3);
        step(); step();

        // rd=0 writeback is consumed silently.
        alu_q.push_back('{5'd0, 32'hDEAD_BEEF});
        a0 = n_acc_alu;
        step(); step(); step();
        chk("rd0_accepted", n_acc_alu - a0, 1);

        // WAW: second write to r4 waits for the first to commit.
        issue_wait(5'd4, 5'd0, 5'd0, 5'd0, n);
        ld_q.push_back('{5'd4, 32'h44});
        issue_wait(5'd4, 5'd1, 5'd2, 5'd0, n);
        chk("waw_release_cycles", n, 3);

        // Reset with a write in flight and r9 busy.
        issue_wait(5'd9, 5'd0, 5'd0, 5'd0, n);
        alu_q.push_back('{5'd9, 32'h99});
        step();
        do_reset();
        issue_wait(5'd0, 5'd9, 5'd0, 5'd0, n);
        chk("post_reset_no_stall", n, 1);
        step(); step();

        // Randomized traffic against the model.
        rand_mode = 1'b1;
        for (int c = 0; c < 400; c++) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_rd    = 5'($urandom_range(0, 31));
            issue_rs1   = 5'($urandom_range(0, 31));
            issue_rs2   = 5'($urandom_range(0, 31));
            issue_rs3   = 5'($urandom_range(0, 31));
            refill(1'b0);
            refill(1'b1);
            step();
        end
        issue_valid = 1'b0;
        n = 0;
        while ((owed.size() > 0 || alu_q.size() > 0 || ld_q.size() > 0 ||
                m_wr_now || any_busy()) && n < 300) begin
            refill(1'b0);
            refill(1'b1);
            step();
            n++;
        end
        chk("drain_in_budget", (n < 300), 1'b1);
        step();
        @(negedge clk);
        chk("final_idle", idle, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_wb_sched

`default_nettype wire

// File: doc/wb_sched.md
WB_SCHED -- requirements
Module: wb_sched

Interface
REQ-001 Parameter RR_INIT, default 1'b1, reset value of the round-robin pointer (1 = load requester wins the first tie).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 issue_valid  input  1  decode presents an instruction this cycle.
REQ-005 issue_rd  input  5  destination register of the presented instruction.
REQ-006 issue_rs1 / issue_rs2 / issue_rs3  input  5 each  source registers of the presented instruction.
REQ-007 issue_stall  output  1  presented instruction must be held (hazard).
REQ-008 alu_valid / alu_rd / alu_val  input  1 / 5 / 32  execute-stage writeback request.
REQ-009 alu_ready  output  1  execute-stage request accepted this cycle.
REQ-010 ld_valid / ld_rd / ld_val  input  1 / 5 / 32  load-return writeback request.
REQ-011 ld_ready  output  1  load-return request accepted this cycle.
REQ-012 w_rd / rd / rd_val  output  1 / 5 / 32  registered drive of the register-file write port.
REQ-013 idle  output  1  no outstanding writes and no write in flight.

Function
REQ-014 Scoreboard: 31 busy bits for r1..r31; r0 has no busy bit and never reads as busy.
REQ-015 issue_stall = issue_valid AND (busy[issue_rs1] OR busy[issue_rs2] OR busy[issue_rs3] OR busy[issue_rd]); combinational; no bypass from the write port.
REQ-016 Issue fires when issue_valid=1 and issue_stall=0; if issue_rd≠0, busy[issue_rd] sets at that clock edge.
REQ-017 Arbitration: at most one request accepted per cycle; valid/ready handshake; ready depends on valid inputs and the pointer only, never on ready.
REQ-018 Single valid requester: that requester gets ready=1.
REQ-019 Both valid: the requester the pointer selects gets ready=1; the pointer then flips to the other requester.
REQ-020 Requester data (rd, val) is sampled only in the accept cycle; an unaccepted requester holds valid and data stable.
REQ-021 Accepted request with rd≠0: next cycle w_rd=1, rd and rd_val equal the accepted values (latency 1 cycle).
REQ-022 Accepted request with rd=0: consumed; w_rd stays 0 next cycle; no scoreboard change.
REQ-023 No accept in a cycle: w_rd=0 next cycle; rd and rd_val hold their previous values.
REQ-024 busy[rd] clears at the clock edge that ends a w_rd=1 cycle; stall therefore remains asserted during that w_rd cycle.
REQ-025 Clear and issue-set of different registers at the same edge both take effect.
REQ-026 Same-register clear and set cannot coincide (REQ-015 stalls issue on busy rd); this is an assertion.
REQ-027 A writeback request for a non-busy nonzero rd is still written; it is flagged by an assertion as a protocol error.
REQ-028 idle = (no busy bit set) AND (w_rd=0).

Reset
REQ-029 While rst_n=0: all busy bits 0, w_rd=0, rd=0, rd_val=0, pointer=RR_INIT; asynchronous assertion, synchronous-to-clk deassertion is the integrator's responsibility.
REQ-030 Reset mid-operation discards every in-flight write and outstanding busy bit; after release idle=1, and no w_rd occurs until a new accept.

Structure
REQ-031 The shared core package holds the register index typedef (5 bits), the data word typedef (32 bits) and the register count constant (32).
REQ-032 The round-robin 2-way arbiter with its pointer flop is the one natural sub-module: wb_rr_arb.
REQ-033 The scoreboard and output register live in wb_sched; no memories, flops only.

Verification
REQ-034 Issue rd=5, then issue rs1=5 next cycle -> stall=1 until the cycle after ALU writes r5 (w_rd=1, rd=5), then stall=0.
REQ-035 ALU rd=3 val=0x11 and load rd=7 val=0x22 both valid from reset with RR_INIT=1 -> ld_ready first, w_rd writes r7=0x22, next cycle alu_ready, w_rd writes r3=0x11.
REQ-036 Both valid continuously for 6 cycles -> grants alternate strictly, 3 each, no cycle without an accept.
REQ-037 Accepted request rd=0 val=0xDEADBEEF -> w_rd stays 0, idle unchanged.
REQ-038 Issue rd=9, pull rst_n low for one cycle mid-sequence -> all outputs at reset values, idle=1, issue with rs1=9 does not stall.
REQ-039 Issue rd=4 (busy), then issue rd=4 again -> second issue stalls (WAW) until r4 write commits.
